// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM
// state encoding and the funct3 -> byte-count mapping.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3)
      F3_H, F3_HU: byte_count = 3'd2;
      F3_W:        byte_count = 3'd4;
      default:     byte_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Load result extension: sign- or zero-extends the assembled little-endian
// bytes according to the funct3 width code.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   result = {24'h0, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   result = {16'h0, raw[15:0]};
      F3_W:    result = raw;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: accepts one CPU request at a time and moves
// 1, 2 or 4 bytes to/from a byte-wide memory, one byte per cycle.
//
// state  | meaning
// IDLE   | ready for a request; legality decided on acceptance
// ACCESS | one memory byte per cycle, index cnt_q = 0..N-1
// DONE   | one-cycle response (resp_valid, optional error)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        error,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [7:0]  mem_read_data
);

  lsu_state_t  state, state_next;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] asm_q;
  logic        err_q;
  logic [1:0]  cnt_q;
  logic [2:0]  nbytes_req;
  logic [2:0]  nbytes_q;
  logic        req_legal;
  logic        last_byte;
  logic [31:0] ext_data;

  always_comb begin
    nbytes_req = byte_count(funct3);
    req_legal  = 1'b1;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
      req_legal = 1'b0;
    if (is_store && (funct3 == F3_BU || funct3 == F3_HU))
      req_legal = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
      req_legal = 1'b0;
    if (funct3 == F3_W && addr[1:0] != 2'b00)
      req_legal = 1'b0;
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    if (({1'b0, addr} + {30'b0, nbytes_req}) > 33'(MEM_BYTES))
      req_legal = 1'b0;
  end

  assign nbytes_q  = byte_count(f3_q);
  assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = req_legal ? ST_ACCESS : ST_DONE;
      ST_ACCESS: if (last_byte) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            st_q    <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            sdata_q <= store_data;
            err_q   <= ~req_legal;
            asm_q   <= '0;
            cnt_q   <= 2'd0;
          end
        end
        ST_ACCESS: begin
          if (!st_q) asm_q[{cnt_q, 3'b000} +: 8] <= mem_read_data;
          cnt_q <= last_byte ? 2'd0 : cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  load_extend u_extend (
    .funct3 (f3_q),
    .raw    (asm_q),
    .result (ext_data)
  );

  always_comb begin
    req_ready        = (state == ST_IDLE);
    resp_valid       = (state == ST_DONE);
    error            = resp_valid && err_q;
    load_data        = (resp_valid && !err_q && !st_q) ? ext_data : 32'h0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (state == ST_ACCESS) begin
      mem_address = addr_q + {30'b0, cnt_q};
      if (st_q) begin
        mem_write_enable = 1'b1;
        mem_write_data   = sdata_q[{cnt_q, 3'b000} +: 8];
      end else begin
        mem_read_enable = 1'b1;
      end
    end
  end

endmodule
